// File: rtl/sentry_victim_reader_pkg.sv
// Shared types for the sentry victim read-back path: CAM index, line and
// response bundle types, plus the default lane/index/line widths.
package sentry_victim_reader_pkg;

  localparam int SENTRY_WIDTH = 4;
  localparam int LINE_WIDTH   = 32;
  localparam int VINDEX_WIDTH = 4;

  typedef logic [VINDEX_WIDTH-1:0] vindex_t;
  typedef logic [LINE_WIDTH-1:0]   line_t;

  typedef struct packed {
    logic [SENTRY_WIDTH-1:0]        lane_valid;
    logic [SENTRY_WIDTH-1:0]        lane_err;
    line_t [SENTRY_WIDTH-1:0]       line;
  } vrsp_t;

endpackage

// File: rtl/sentry_victim_reader_if.sv
// Request/CAM/response bundle between the sentry replay logic and the
// victim reader; slave is the reader's view, master the client's.
interface sentry_victim_reader_if
  import sentry_victim_reader_pkg::*;
#(
  parameter int WIDTH      = SENTRY_WIDTH,
  parameter int ADDR_WIDTH = VINDEX_WIDTH,
  parameter int LINE_W     = LINE_WIDTH
);
  logic [WIDTH-1:0]                  cache_evicted;
  logic [WIDTH-1:0]                  req_valid;
  logic [WIDTH-1:0][ADDR_WIDTH-1:0]  req_index;
  logic                              req_ready;
  logic [WIDTH-1:0][ADDR_WIDTH-1:0]  victim_cam_index;
  logic [WIDTH-1:0][LINE_W-1:0]      victim_cam_line;
  logic                              rsp_valid;
  logic                              rsp_ready;
  logic [WIDTH-1:0]                  rsp_lane_valid;
  logic [WIDTH-1:0]                  rsp_lane_err;
  logic [WIDTH-1:0][LINE_W-1:0]      rsp_line;
  logic [ADDR_WIDTH:0]               occupancy;
  logic                              err_empty_read;
  logic                              err_overwrite;

  modport slave (
    input  cache_evicted, req_valid, req_index, victim_cam_line, rsp_ready,
    output req_ready, victim_cam_index, rsp_valid, rsp_lane_valid,
           rsp_lane_err, rsp_line, occupancy, err_empty_read, err_overwrite
  );

  modport master (
    output cache_evicted, req_valid, req_index, victim_cam_line, rsp_ready,
    input  req_ready, victim_cam_index, rsp_valid, rsp_lane_valid,
           rsp_lane_err, rsp_line, occupancy, err_empty_read, err_overwrite
  );
endinterface

// File: rtl/sentry_victim_rsp_fifo.sv
// Two-entry response bundle FIFO; head is shown directly on the output and
// stays stable until popped.
module sentry_victim_rsp_fifo
  import sentry_victim_reader_pkg::*;
#(
  parameter type entry_t = vrsp_t
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  entry_t     push_data,
  input  logic       pop,
  output entry_t     head,
  output logic [1:0] count
);
  entry_t     mem_reg [2];
  logic       wr_ptr_reg;
  logic       rd_ptr_reg;
  logic [1:0] count_reg;

  // The upstream credit check guarantees push never lands on a full FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) mem_reg[i] <= '0;
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (push) begin
        mem_reg[wr_ptr_reg] <= push_data;
        wr_ptr_reg          <= ~wr_ptr_reg;
      end
      if (pop) rd_ptr_reg <= ~rd_ptr_reg;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head  = mem_reg[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/sentry_victim_reader.sv
// Victim CAM read-back: tracks which CAM entries hold unconsumed victims by
// mirroring the eviction write pointer, and returns read lines in order.
module sentry_victim_reader
  import sentry_victim_reader_pkg::*;
#(
  parameter int ADDR_WIDTH = VINDEX_WIDTH,
  parameter int WIDTH      = SENTRY_WIDTH,
  parameter int LINE_W     = LINE_WIDTH
) (
  input logic                   clk,
  input logic                   rst_n,
  sentry_victim_reader_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef struct packed {
    logic [WIDTH-1:0]             lane_valid;
    logic [WIDTH-1:0]             lane_err;
    logic [WIDTH-1:0][LINE_W-1:0] line;
  } bundle_t;

  logic [ADDR_WIDTH-1:0]            ptr_reg;
  logic [ADDR_WIDTH-1:0]            ptr_next;
  logic [WIDTH-1:0][ADDR_WIDTH-1:0] wr_idx;
  logic [DEPTH-1:0]                 live_reg;
  logic [DEPTH-1:0]                 live_next;
  logic [DEPTH-1:0]                 written;
  logic [DEPTH-1:0]                 read_clr;
  logic [WIDTH-1:0]                 lane_err;
  logic                             overwrite_hit;
  logic                             inflight_reg;
  logic [WIDTH-1:0]                 mask_reg;
  logic [WIDTH-1:0]                 err_reg;
  logic                             err_empty_reg;
  logic                             err_overwrite_reg;
  logic                             fire;
  logic                             req_ready;
  logic                             rsp_valid;
  logic                             pop;
  logic [1:0]                       fifo_count;
  logic [2:0]                       credit_used;
  logic [ADDR_WIDTH:0]              occ;
  bundle_t                          push_data;
  bundle_t                          head;

  // Lane k writes at ptr plus the number of evicting lanes below it.
  always_comb begin
    ptr_next = ptr_reg;
    for (int k = 0; k < WIDTH; k++) begin
      wr_idx[k] = ptr_next;
      ptr_next  = ptr_next + {{(ADDR_WIDTH-1){1'b0}}, bus.cache_evicted[k]};
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [WIDTH-1:0] wr_hit;
    logic [WIDTH-1:0] rd_hit;
    for (genvar gk = 0; gk < WIDTH; gk++) begin : g_lane
      assign wr_hit[gk] = bus.cache_evicted[gk] && (wr_idx[gk] == ADDR_WIDTH'(gi));
      assign rd_hit[gk] = bus.req_valid[gk] && (bus.req_index[gk] == ADDR_WIDTH'(gi));
    end
    assign written[gi]  = |wr_hit;
    assign read_clr[gi] = fire && (|rd_hit);
  end

  // A same-cycle write to the read index counts as a live victim.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_err
    assign lane_err[gi] = bus.req_valid[gi] &&
        !(live_reg[bus.req_index[gi]] || written[bus.req_index[gi]]);
  end

  assign live_next     = (live_reg & ~read_clr) | written;
  assign overwrite_hit = |(written & live_reg & ~read_clr);

  always_comb begin
    occ = '0;
    for (int i = 0; i < DEPTH; i++) occ = occ + {{ADDR_WIDTH{1'b0}}, live_reg[i]};
  end

  // Credit covers both buffered bundles and the one waiting on CAM data.
  assign rsp_valid   = (fifo_count != 2'd0);
  assign pop         = rsp_valid && bus.rsp_ready;
  assign credit_used = {1'b0, fifo_count} + {2'b00, inflight_reg} - {2'b00, pop};
  assign req_ready   = (credit_used < 3'd2);
  assign fire        = (|bus.req_valid) && req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg           <= '0;
      live_reg          <= '0;
      inflight_reg      <= 1'b0;
      mask_reg          <= '0;
      err_reg           <= '0;
      err_empty_reg     <= 1'b0;
      err_overwrite_reg <= 1'b0;
    end else begin
      ptr_reg      <= ptr_next;
      live_reg     <= live_next;
      inflight_reg <= fire;
      if (fire) begin
        mask_reg <= bus.req_valid;
        err_reg  <= lane_err;
      end
      if (fire && (|lane_err)) err_empty_reg <= 1'b1;
      if (overwrite_hit) err_overwrite_reg <= 1'b1;
    end
  end

  assign push_data = {mask_reg, err_reg, bus.victim_cam_line};

  sentry_victim_rsp_fifo #(
    .entry_t (bundle_t)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight_reg),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count)
  );

  assign bus.req_ready        = req_ready;
  assign bus.victim_cam_index = bus.req_index;
  assign bus.rsp_valid        = rsp_valid;
  assign bus.rsp_lane_valid   = head.lane_valid;
  assign bus.rsp_lane_err     = head.lane_err;
  assign bus.rsp_line         = head.line;
  assign bus.occupancy        = occ;
  assign bus.err_empty_read   = err_empty_reg;
  assign bus.err_overwrite    = err_overwrite_reg;

endmodule

// File: tb/tb_sentry_victim_reader.sv
// Bench for sentry_victim_reader: table vectors, directed corner sequences and
// random traffic against an entry-set / response-queue reference model.
module tb_sentry_victim_reader;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  sentry_victim_reader_if bus ();

  sentry_victim_reader dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [31:0] cam_word(input int idx, input int lane, input int c);
    return {4'(lane), 4'(idx), 24'(c)};
  endfunction

  // CAM model: read data for the index presented at an edge appears after it.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int k = 0; k < 4; k++)
      bus.victim_cam_line[k] <= cam_word(int'(bus.victim_cam_index[k]), k, cyc);
  end

  typedef struct {
    int               cyc;
    logic [3:0]       lv;
    logic [3:0]       le;
    logic [3:0][31:0] line;
  } exp_t;

  exp_t      q[$];
  bit [15:0] live_m;
  int        ptr_m;
  bit        emp_m;
  bit        ovw_m;
  logic      obs_ready, obs_valid;
  logic [3:0] obs_err;
  int        obs_fires, obs_pops;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input logic [3:0] ev, input logic [3:0] rv,
                      input logic [3:0][3:0] idx, input logic rr);
    bit [15:0]  wr, rd;
    logic [3:0] le;
    logic [3:0][31:0] ln;
    bit ev_valid, ev_ready;
    int p;
    bus.cache_evicted = ev;
    bus.req_valid     = rv;
    bus.req_index     = idx;
    bus.rsp_ready     = rr;
    @(negedge clk);
    ev_valid = (q.size() > 0) && (q[0].cyc + 2 <= cyc);
    ev_ready = (q.size() - ((ev_valid && rr) ? 1 : 0)) < 2;
    obs_ready = bus.req_ready;
    obs_valid = bus.rsp_valid;
    obs_err   = bus.rsp_lane_err;
    if ((rv != 0) && bus.req_ready) obs_fires++;
    if (bus.rsp_valid && rr) obs_pops++;
    chk("req_ready", bus.req_ready, ev_ready);
    chk("rsp_valid", bus.rsp_valid, ev_valid);
    chk("cam_index", bus.victim_cam_index, idx);
    if (ev_valid) begin
      chk("rsp_lane_valid", bus.rsp_lane_valid, q[0].lv);
      chk("rsp_lane_err", bus.rsp_lane_err, q[0].le);
      for (int k = 0; k < 4; k++)
        if (q[0].lv[k]) chk($sformatf("rsp_line%0d", k), bus.rsp_line[k], q[0].line[k]);
      if (rr) void'(q.pop_front());
    end
    wr = '0;
    rd = '0;
    p  = ptr_m;
    for (int k = 0; k < 4; k++)
      if (ev[k]) begin
        wr[p] = 1'b1;
        p = (p + 1) % 16;
      end
    ptr_m = p;
    for (int k = 0; k < 4; k++) begin
      le[k] = rv[k] && !(live_m[idx[k]] || wr[idx[k]]);
      ln[k] = rv[k] ? cam_word(int'(idx[k]), k, cyc) : 32'h0;
    end
    if ((rv != 0) && ev_ready) begin
      for (int k = 0; k < 4; k++) if (rv[k]) rd[idx[k]] = 1'b1;
      q.push_back('{cyc, rv, le, ln});
      if (le != 0) emp_m = 1'b1;
    end
    if ((wr & live_m & ~rd) != 0) ovw_m = 1'b1;
    live_m = (live_m & ~rd) | wr;
    @(posedge clk);
    #1;
    chk("occupancy", bus.occupancy, $countones(live_m));
    chk("err_empty_read", bus.err_empty_read, emp_m);
    chk("err_overwrite", bus.err_overwrite, ovw_m);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(4'b0, 4'b0, 16'h0, 1'b1);
  endtask

  task automatic do_reset();
    bus.cache_evicted = '0;
    bus.req_valid     = '0;
    bus.req_index     = '0;
    bus.rsp_ready     = 1'b0;
    rst_n = 1'b0;
    #2;
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_lane_valid", bus.rsp_lane_valid, 4'h0);
    chk("rst_lane_err", bus.rsp_lane_err, 4'h0);
    chk("rst_rsp_line", |bus.rsp_line, 1'b0);
    chk("rst_occupancy", bus.occupancy, 5'd0);
    chk("rst_err_empty", bus.err_empty_read, 1'b0);
    chk("rst_err_ovw", bus.err_overwrite, 1'b0);
    q.delete();
    live_m = '0;
    ptr_m  = 0;
    emp_m  = 1'b0;
    ovw_m  = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("rst_req_ready", bus.req_ready, 1'b1);
  endtask

  typedef struct {
    logic [3:0]      ev;
    logic [3:0]      rv;
    logic [3:0][3:0] idx;
    int              occ;
    logic            ready;
    logic            rvalid;
    logic [3:0]      rerr;
  } row_t;

  row_t tbl[5];
  int   f0, p0;

  initial begin
    tbl[0] = '{4'b0101, 4'b0000, 16'h0000, 2, 1'b1, 1'b0, 4'h0};
    tbl[1] = '{4'b0000, 4'b0011, 16'h0010, 0, 1'b1, 1'b0, 4'h0};
    tbl[2] = '{4'b0000, 4'b0000, 16'h0000, 0, 1'b1, 1'b0, 4'h0};
    tbl[3] = '{4'b0000, 4'b0000, 16'h0000, 0, 1'b1, 1'b1, 4'h0};
    tbl[4] = '{4'b0000, 4'b0000, 16'h0000, 0, 1'b1, 1'b0, 4'h0};

    #1;
    do_reset();

    // Evict lanes 0,2 then read indices 0 and 1.
    for (int i = 0; i < 5; i++) begin
      tick(tbl[i].ev, tbl[i].rv, tbl[i].idx, 1'b1);
      chk($sformatf("tbl%0d_occ", i), bus.occupancy, tbl[i].occ);
      chk($sformatf("tbl%0d_ready", i), obs_ready, tbl[i].ready);
      chk($sformatf("tbl%0d_rvalid", i), obs_valid, tbl[i].rvalid);
      if (tbl[i].rvalid) chk($sformatf("tbl%0d_rerr", i), obs_err, tbl[i].rerr);
    end

    // Read of an empty entry.
    tick(4'b0, 4'b0001, 16'h0005, 1'b1);
    idle(2);
    chk("empty_rvalid", obs_valid, 1'b1);
    chk("empty_lane_err", obs_err, 4'b0001);
    idle(3);
    chk("empty_sticky", bus.err_empty_read, 1'b1);

    // 17 single evictions: wrap and overwrite.
    do_reset();
    for (int i = 0; i < 16; i++) tick(4'b0001, 4'b0, 16'h0, 1'b1);
    chk("ovw_before", bus.err_overwrite, 1'b0);
    chk("occ_full", bus.occupancy, 5'd16);
    tick(4'b0001, 4'b0, 16'h0, 1'b1);
    chk("ovw_after", bus.err_overwrite, 1'b1);
    chk("occ_sat", bus.occupancy, 5'd16);
    tick(4'b0, 4'b1111, 16'h3210, 1'b1);
    chk("occ_after_clr", bus.occupancy, 5'd12);
    tick(4'b0001, 4'b0, 16'h0, 1'b1);
    tick(4'b0, 4'b0011, 16'h0010, 1'b1);
    idle(2);
    chk("wrap_rvalid", obs_valid, 1'b1);
    chk("wrap_ptr_err", obs_err, 4'b0001);

    // Same-cycle write and read of index 3.
    do_reset();
    for (int i = 0; i < 3; i++) tick(4'b0001, 4'b0, 16'h0, 1'b1);
    tick(4'b0001, 4'b0001, 16'h0003, 1'b1);
    chk("same_occ", bus.occupancy, 5'd4);
    idle(2);
    chk("same_rvalid", obs_valid, 1'b1);
    chk("same_err", obs_err, 4'b0000);
    tick(4'b0, 4'b0001, 16'h0003, 1'b1);
    chk("same_live3_occ", bus.occupancy, 5'd3);
    idle(2);
    chk("same_live3_err", obs_err, 4'b0000);

    // Back-pressure with requests every cycle.
    idle(2);
    f0 = obs_fires;
    for (int i = 0; i < 5; i++) tick(4'b0, 4'b0001, 16'(i + 8), 1'b0);
    chk("bp_accepted", obs_fires - f0, 2);
    chk("bp_ready_low", obs_ready, 1'b0);
    p0 = obs_pops;
    idle(4);
    chk("bp_delivered", obs_pops - p0, 2);

    // Reset while FIFO holds two bundles.
    for (int i = 0; i < 4; i++) tick(4'b0, 4'b0001, 16'h0001, 1'b0);
    chk("full_rvalid", bus.rsp_valid, 1'b1);
    chk("full_ready", bus.req_ready, 1'b0);
    do_reset();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      logic [3:0] ev, rv;
      ev = 4'($urandom) & 4'($urandom);
      rv = ($urandom_range(0, 2) == 0) ? 4'b0 : 4'($urandom);
      tick(ev, rv, 16'($urandom), $urandom_range(0, 3) != 0);
    end
    idle(4);
    chk("drain_empty", bus.rsp_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
